// File: rtl/cfu_init_pkg.sv
// Shared state encoding, default widths and sizing helper for the CFU initiator.
package cfu_init_pkg;

  localparam int unsigned DEF_FUNCTION_ID_W  = 1;
  localparam int unsigned DEF_REQ_DATA_W     = 32;
  localparam int unsigned DEF_RESP_DATA_W    = 32;
  localparam int unsigned DEF_MAX_OUT        = 4;
  localparam int unsigned DEF_SUM_W          = 16;
  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cfu_init_state_e;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int unsigned outstanding_w(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/cfu_init_watchdog.sv
// Response watchdog: reloads on i_load, counts armed cycles, flags expiry on the LIMIT-th one.
module cfu_init_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire_c = i_count & ~i_load & (r_cnt == CW'(LIMIT - 1));

  // Armed-cycle counter; restarts on reload or after firing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load || o_expire_c) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cfu_popcount_initiator.sv
// Requester-side CFU engine: streams packet words into a handshaked CFU, sums the
// responses and reports packet total/count. Optional watchdog: CFU_INIT_TIMEOUT_EN.
module cfu_popcount_initiator
  import cfu_init_pkg::*;
#(
  parameter int unsigned CFU_FUNCTION_ID_W = DEF_FUNCTION_ID_W,
  parameter int unsigned CFU_REQ_DATA_W    = DEF_REQ_DATA_W,
  parameter int unsigned CFU_RESP_DATA_W   = DEF_RESP_DATA_W,
  parameter int unsigned FUNC_ID           = 0,
  parameter int unsigned MAX_OUT           = DEF_MAX_OUT,
  parameter int unsigned SUM_W             = DEF_SUM_W,
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CFU_REQ_DATA_W-1:0]    in_data,
  input  logic                         in_last,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0] req_function_id,
  output logic [CFU_REQ_DATA_W-1:0]    req_data,
  input  logic                         resp_valid,
  output logic                         resp_ready,
  input  logic [CFU_RESP_DATA_W-1:0]   resp_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_W-1:0]             out_sum,
  output logic [CNT_W-1:0]             out_count,
  output logic                         out_err
);

  localparam int unsigned OUT_W  = outstanding_w(MAX_OUT);
  localparam int unsigned SUM_XW = SUM_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  cfu_init_state_e   r_state, w_state_nxt;
  logic [OUT_W-1:0]  r_outst, w_outst_nxt;
  logic [SUM_W-1:0]  r_sum, w_sum_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_err, w_err_nxt;
  logic              r_out_valid;
  logic [SUM_W-1:0]  r_out_sum;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_err;
  logic              w_busy, w_room, w_req_fire, w_resp_fire, w_spurious, w_resp_ok;
  logic              w_resp_hi_nz, w_wd_expire;
  logic [SUM_XW-1:0] w_sum_ext;

  assign req_function_id = CFU_FUNCTION_ID_W'(FUNC_ID);
  assign req_data        = in_data;
  assign out_valid       = r_out_valid;
  assign out_sum         = r_out_sum;
  assign out_count       = r_out_count;
  assign out_err         = r_out_err;

  // Response bits above the accumulator width count as overflow.
  if (CFU_RESP_DATA_W > SUM_W) begin : g_resp_hi
    assign w_resp_hi_nz = |resp_data[CFU_RESP_DATA_W-1:SUM_W];
  end else begin : g_resp_no_hi
    assign w_resp_hi_nz = 1'b0;
  end

`ifdef CFU_INIT_TIMEOUT_EN
  cfu_init_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_resp_fire | (r_outst == '0)),
    .i_count   (w_busy & (r_outst != '0)),
    .o_expire_c(w_wd_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_wd_expire      = 1'b0;
`endif

  // Handshakes, accumulator/counter updates and next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_outst_nxt = r_outst;
    w_sum_nxt   = r_sum;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_sum_ext   = '0;

    w_busy      = (r_state == RUN) || (r_state == DRAIN);
    w_room      = r_outst < OUT_W'(MAX_OUT);
    req_valid   = (r_state == RUN) & in_valid & w_room;
    in_ready    = (r_state == RUN) & req_ready & w_room;
    resp_ready  = w_busy;
    w_req_fire  = req_valid & req_ready;
    w_resp_fire = resp_valid & resp_ready;
    // A combinational CFU answers in the issue cycle, so that response is legitimate.
    w_spurious  = w_resp_fire & (r_outst == '0) & ~w_req_fire;
    w_resp_ok   = w_resp_fire & ~w_spurious;

    if (w_req_fire) begin
      if (r_count == CNT_MAX) begin
        w_err_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end

    if (w_resp_ok) begin
      w_sum_ext = SUM_XW'(r_sum) + SUM_XW'(resp_data[SUM_W-1:0]);
      w_sum_nxt = w_sum_ext[SUM_W-1:0];
      if (w_sum_ext[SUM_W] || w_resp_hi_nz) begin
        w_err_nxt = 1'b1;
      end
    end

    if (w_spurious) begin
      w_err_nxt = 1'b1;
    end

    if (w_req_fire && !w_resp_ok) begin
      w_outst_nxt = r_outst + OUT_W'(1);
    end else if (!w_req_fire && w_resp_ok) begin
      w_outst_nxt = r_outst - OUT_W'(1);
    end

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = RUN;
          w_sum_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      RUN: begin
        if (w_req_fire && in_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_outst_nxt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_wd_expire && w_busy) begin
      w_state_nxt = DONE;
      w_err_nxt   = 1'b1;
      w_outst_nxt = '0;
    end
  end

  // State and packet accumulators.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_outst <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      r_sum   <= w_sum_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Result port: captured on DONE entry and held until consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else if ((r_state != DONE) && (w_state_nxt == DONE)) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum_nxt;
      r_out_count <= w_count_nxt;
      r_out_err   <= w_err_nxt;
    end else if ((r_state == DONE) && (w_state_nxt == IDLE)) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfu_popcount_initiator.sv
// Bench for cfu_popcount_initiator: directed packets through a behavioural CFU,
// expected results queued at issue and checked by an independent result monitor.
module tb_cfu_popcount_initiator;

  localparam int unsigned TB_MAX_OUT = 2;

  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  logic        clock, reset_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        req_valid, req_ready;
  logic [0:0]  req_function_id;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        out_valid, out_ready, out_err;
  logic [15:0] out_sum, out_count;

  // CFU model controls, written only by the main sequence
  logic        comb_mode, ident, inj_valid, hold_ready;
  logic [31:0] inj_data;
  int          lat_min, lat_max, stall_pct, sink_delay;

  // CFU model outputs
  logic        m_resp_v;
  logic [31:0] m_resp_d;
  logic [31:0] w_comb_d;

  exp_t        exp_q[$];
  logic [31:0] pkt[$];
  int          n_vec, n_miss;

  assign w_comb_d   = ident ? req_data : 32'($countones(req_data));
  assign resp_valid = comb_mode ? (req_valid & req_ready) : (inj_valid | m_resp_v);
  assign resp_data  = comb_mode ? w_comb_d : (inj_valid ? inj_data : m_resp_d);

  cfu_popcount_initiator #(
    .MAX_OUT(TB_MAX_OUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_function_id(req_function_id),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_count      (out_count),
    .out_err        (out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural CFU: in-order, per-request latency, random req_ready stalls.
  initial begin : cfu_model
    logic [31:0] pend_d[$];
    int          pend_t[$];
    int          c;
    c = 0;
    m_resp_v  = 1'b0;
    m_resp_d  = 32'h0;
    req_ready = 1'b0;
    forever begin
      @(negedge clock);
      c++;
      if (!reset_n) begin
        pend_d.delete();
        pend_t.delete();
      end
      if (pend_t.size() > 0 && pend_t[0] <= c) begin
        m_resp_v = 1'b1;
        m_resp_d = pend_d[0];
      end else begin
        m_resp_v = 1'b0;
        m_resp_d = 32'h0;
      end
      req_ready = !hold_ready && (int'($urandom_range(99, 0)) >= stall_pct);
      #1;
      if (reset_n && !comb_mode) begin
        if (pend_d.size() >= TB_MAX_OUT) chk("req_valid_at_max_out", 32'(req_valid), 32'd0);
        if (m_resp_v && resp_ready && !inj_valid) begin
          void'(pend_d.pop_front());
          void'(pend_t.pop_front());
        end
        if (req_valid && req_ready) begin
          pend_d.push_back(ident ? req_data : 32'($countones(req_data)));
          pend_t.push_back(c + int'($urandom_range(lat_max, lat_min)));
        end
      end
    end
  end

  // Result monitor: compares every presented result against the queue head.
  initial begin : monitor
    int   hold_cnt;
    logic popped;
    exp_t e;
    hold_cnt  = 0;
    popped    = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (!out_valid) hold_cnt = sink_delay;
      out_ready = out_valid && (hold_cnt == 0);
      #1;
      if (popped) chk("out_valid_drop", 32'(out_valid), 32'd0);
      popped = 1'b0;
      if (reset_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_result: got sum 0x%0h count %0d, expected no result", out_sum, out_count);
        end else begin
          e = exp_q[0];
          chk("out_sum", 32'(out_sum), 32'(e.sum));
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_err", 32'(out_err), 32'(e.err));
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped = 1'b1;
          end else begin
            hold_cnt--;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready && guard < 2000) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL in_handshake: in_ready %0b, expected 1 within 2000 cycles", in_ready);
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [15:0] es, input logic [15:0] ec, input logic ee);
    exp_q.push_back('{sum: es, cnt: ec, err: ee});
    foreach (pkt[i]) send_word(pkt[i], 1'(i == pkt.size() - 1));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
  endtask

  initial begin : global_limit
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    n_vec = 0;     n_miss = 0;
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    comb_mode = 1'b0; ident = 1'b0; inj_valid = 1'b0; inj_data = 32'h0; hold_ready = 1'b0;
    lat_min = 1; lat_max = 1; stall_pct = 0; sink_delay = 0;
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs();
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // single word, latency 1, result held 5 cycles before consumption
    sink_delay = 5;
    pkt = '{32'hFFFF_FFFF};
    send_packet(16'd32, 16'd1, 1'b0);
    wait_drain();

    // mixed words with stalls and latency 1..3, then through a combinational CFU
    sink_delay = 1; stall_pct = 40; lat_min = 1; lat_max = 3;
    pkt = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hF0F0_F0F0};
    send_packet(16'd26, 16'd5, 1'b0);
    wait_drain();
    comb_mode = 1'b1; stall_pct = 30;
    send_packet(16'd26, 16'd5, 1'b0);
    wait_drain();
    comb_mode = 1'b0;

    // long latency saturates the outstanding limit
    stall_pct = 0; lat_min = 6; lat_max = 6; sink_delay = 0;
    pkt = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
    send_packet(16'd64, 16'd8, 1'b0);
    wait_drain();

    // back-to-back issue with a response retiring in the same cycle
    lat_min = 1; lat_max = 1;
    pkt = '{32'h0000_FFFF, 32'h1, 32'h8000_0000, 32'h3, 32'h0, 32'hAAAA_AAAA};
    send_packet(16'd36, 16'd6, 1'b0);
    wait_drain();

    // identity CFU: accumulator wrap, high-bit overflow, then clean packet
    ident = 1'b1; lat_min = 1; lat_max = 2;
    pkt = '{32'h8000, 32'h8001};
    send_packet(16'h0001, 16'd2, 1'b1);
    wait_drain();
    pkt = '{32'h0001_2345};
    send_packet(16'h2345, 16'd1, 1'b1);
    wait_drain();
    pkt = '{32'h1234, 32'h0100};
    send_packet(16'h1334, 16'd2, 1'b0);
    wait_drain();
    ident = 1'b0;

    // reset mid-packet, then a stale response in RUN with nothing outstanding
    lat_min = 6; lat_max = 6;
    send_word(32'h1, 1'b0);
    send_word(32'h3, 1'b0);
    hold_ready = 1'b1;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    in_data    = 32'h7;
    #1;
    check_reset_outputs();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    in_last = 1'b1;
    exp_q.push_back('{sum: 16'd3, cnt: 16'd1, err: 1'b1});
    @(negedge clock);
    inj_valid = 1'b1;
    inj_data  = 32'h0000_0005;
    #1;
    chk("stale_resp_ready", 32'(resp_ready), 32'd1);
    @(negedge clock);
    inj_valid  = 1'b0;
    hold_ready = 1'b0;
    send_word(32'h7, 1'b1);
    wait_drain();

    // error flag cleared by the previous result hand-off
    lat_min = 1; lat_max = 1;
    pkt = '{32'h3};
    send_packet(16'd2, 16'd1, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
